// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full_adder cell plus a carry flip-flop, LSB first
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] shift_a, shift_b, shift_s, next_s;
  logic [CW-1:0]    count;
  logic             carry, fa_sum, fa_carry, last, load;
  full_adder u_fa (
    .a     (shift_a[0]),
    .b     (shift_b[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );
  assign last   = count == CW'(WIDTH - 1);
  assign load   = start && state != RUN;
  assign next_s = (shift_s >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  // IDLE and DONE both accept a new start; RUN ends on the last bit
  always_comb
    state_nx = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  // status decoded straight from the registered state
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  // operand load, per-bit shifting, and result capture on the final bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shift_a <= '0;
      shift_b <= '0;
      shift_s <= '0;
      carry   <= 1'b0;
      count   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (load) begin
      shift_a <= a;
      shift_b <= b;
      carry   <= cin;
      count   <= '0;
    end else if (state == RUN) begin
      shift_a <= shift_a >> 1;
      shift_b <= shift_b >> 1;
      shift_s <= next_s;
      carry   <= fa_carry;
      count   <= count + CW'(1);
      if (last) begin
        sum  <= next_s;
        cout <= fa_carry;
      end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH 8 and WIDTH 4
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0, sum;
  logic       busy, done, cout;
  logic       start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       busy4, done4, cout4;
  logic [8:0] exp_q[$];
  logic [4:0] exp4_q[$];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic start8(input logic [7:0] xa, input logic [7:0] xb, input logic xc);
    start = 1'b1; a = xa; b = xb; cin = xc;
    exp_q.push_back({1'b0, xa} + {1'b0, xb} + {8'd0, xc});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done8(output int cyc, output int bcnt, output bit ok);
    cyc = 0; bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    ok = done;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, cout, sum} !== 11'd0) begin n_err++; $display("FAIL reset_outputs: got %b expected 0", {busy, done, cout, sum}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy, done, busy4, done4} !== 4'd0) begin n_err++; $display("FAIL reset_idle: got %b expected 0", {busy, done, busy4, done4}); end
  endtask

  task automatic test_basic;
    int cyc, bcnt; bit ok; logic [8:0] e;
    start8(8'h3C, 8'h5A, 1'b0);
    wait_done8(cyc, bcnt, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_timeout: done not seen after %0d cycles", cyc); end
    n_cmp++; if (bcnt != 8) begin n_err++; $display("FAIL basic_busy_cycles: got %0d expected 8", bcnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_in_done: got %b expected 0", busy); end
    e = exp_q.pop_front();
    n_cmp++; if ({cout, sum} !== e) begin n_err++; $display("FAIL basic_sum: got %h expected %h", {cout, sum}, e); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    n_cmp++; if ({cout, sum} !== e) begin n_err++; $display("FAIL basic_hold: got %h expected %h", {cout, sum}, e); end
  endtask

  task automatic test_carry;
    int cyc, bcnt; bit ok; logic [8:0] e;
    start8(8'hFF, 8'h01, 1'b0);
    wait_done8(cyc, bcnt, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || {cout, sum} !== e) begin n_err++; $display("FAIL carry_ff_01: got %h done %b expected %h", {cout, sum}, ok, e); end
    @(negedge clk);
    start8(8'hFF, 8'hFF, 1'b1);
    wait_done8(cyc, bcnt, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || {cout, sum} !== e) begin n_err++; $display("FAIL carry_ff_ff_1: got %h done %b expected %h", {cout, sum}, ok, e); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({cout, sum} !== e || done !== 1'b0) begin n_err++; $display("FAIL carry_hold: got %h done %b expected %h done 0", {cout, sum}, done, e); end
  endtask

  task automatic test_ignore_start;
    int cyc, bcnt; bit ok; logic [8:0] e;
    start8(8'h10, 8'h20, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done8(cyc, bcnt, ok);
    n_cmp++; if (!ok || cyc != 5) begin n_err++; $display("FAIL ignore_timing: done %b after %0d cycles expected 5", ok, cyc); end
    e = exp_q.pop_front();
    n_cmp++; if ({cout, sum} !== e) begin n_err++; $display("FAIL ignore_sum: got %h expected %h", {cout, sum}, e); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc, bcnt; bit ok; logic [8:0] e;
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    repeat (3) exp_q.push_back(9'h002);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      wait_done8(cyc, bcnt, ok);
      n_cmp++; if (!ok || cyc != 8 || bcnt != 8) begin n_err++; $display("FAIL b2b_timing[%0d]: done %b cycles %0d busy %0d expected 8/8", k, ok, cyc, bcnt); end
      e = exp_q.pop_front();
      n_cmp++; if ({cout, sum} !== e || busy !== 1'b0) begin n_err++; $display("FAIL b2b_sum[%0d]: got %h busy %b expected %h busy 0", k, {cout, sum}, busy, e); end
      if (k == 2) start = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_stop: busy got %b expected 0", busy); end
  endtask

  task automatic test_async_reset;
    int cyc, bcnt; bit ok; logic [8:0] e;
    start8(8'h80, 8'h80, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    n_cmp++; if ({busy, done, cout, sum} !== 11'd0) begin n_err++; $display("FAIL async_reset: got %b expected 0", {busy, done, cout, sum}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start8(8'h01, 8'h02, 1'b0);
    wait_done8(cyc, bcnt, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || {cout, sum} !== e) begin n_err++; $display("FAIL after_reset_sum: got %h done %b expected %h", {cout, sum}, ok, e); end
    @(negedge clk);
  endtask

  task automatic test_w4_sweep;
    int cyc; logic [4:0] e;
    for (int i = 0; i < 512; i++) begin
      start4 = 1'b1; a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8];
      exp4_q.push_back({1'b0, i[3:0]} + {1'b0, i[7:4]} + {4'd0, i[8]});
      @(negedge clk);
      start4 = 1'b0;
      cyc = 0;
      while (!done4 && cyc < 20) begin @(negedge clk); cyc++; end
      e = exp4_q.pop_front();
      n_cmp++; if (!done4 || cyc != 4) begin n_err++; $display("FAIL w4_timing[%0d]: done %b after %0d cycles expected 4", i, done4, cyc); end
      n_cmp++; if ({cout4, sum4} !== e) begin n_err++; $display("FAIL w4_sum[%0d]: got %h expected %h", i, {cout4, sum4}, e); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_ignore_start;
    test_back_to_back;
    test_async_reset;
    test_w4_sweep;
    n_cmp++; if (exp_q.size() != 0 || exp4_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover: %0d/%0d entries expected 0", exp_q.size(), exp4_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
